triangle_setup: RTL and testbench

Stage directly downstream of the primitive assembler. It buffers each screen-space triangle the assembler emits on its data-valid strobe, then computes the three edge-function coefficients and twice the signed area. It culls degenerate triangles, and back-facing ones when configured. Surviving triangles go to the rasterizer over a valid/ready handshake. The assembler cannot be stalled, so an input FIFO absorbs bursts and overflow is flagged.

---
 rtl/triangle_setup.sv | 223 ++++++++++++++++++++++
 tb/tb_triangle_setup.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_setup.sv
// Triangle setup: buffers assembler triangles in a small FIFO, then derives edge
// functions and twice the signed area. Optional macro BACKFACE_CULL_EN culls area < 0.
module triangle_setup #(
    parameter int DATAWIDTH      = 12,
    parameter int DEPTH_FRACBITS = 12,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_dv,
    input  logic signed [DATAWIDTH-1:0]     i_vertex_pixel [3][2],
    input  logic        [DEPTH_FRACBITS-1:0] i_vertex_z [3],
    input  logic signed [DATAWIDTH-1:0]     i_bb_tl [2],
    input  logic signed [DATAWIDTH-1:0]     i_bb_br [2],
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic signed [DATAWIDTH:0]       o_edge_a [3],
    output logic signed [DATAWIDTH:0]       o_edge_b [3],
    output logic signed [2*DATAWIDTH:0]     o_edge_c [3],
    output logic signed [2*DATAWIDTH+1:0]   o_area,
    output logic        [DEPTH_FRACBITS-1:0] o_vertex_z [3],
    output logic signed [DATAWIDTH-1:0]     o_bb_tl [2],
    output logic signed [DATAWIDTH-1:0]     o_bb_br [2],
    output logic                            o_idle,
    output logic                            o_overflow,
    output logic        [15:0]              o_cull_count
);

    localparam int DW = DATAWIDTH;
    localparam int ZW = DEPTH_FRACBITS;
    localparam int EW = DW + 1;
    localparam int CW = 2 * DW + 1;
    localparam int RW = 2 * DW + 2;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EDGE, S_AREA, S_OUT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;

    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full, push, pop;

    logic signed [DW-1:0] mem_pix_q [FIFO_DEPTH][3][2];
    logic        [ZW-1:0] mem_z_q   [FIFO_DEPTH][3];
    logic signed [DW-1:0] mem_tl_q  [FIFO_DEPTH][2];
    logic signed [DW-1:0] mem_br_q  [FIFO_DEPTH][2];

    logic signed [DW-1:0] pix_q [3][2];
    logic        [ZW-1:0] z_q   [3];
    logic signed [DW-1:0] tl_q  [2];
    logic signed [DW-1:0] br_q  [2];
    logic signed [EW-1:0] a_q   [3];
    logic signed [EW-1:0] b_q   [3];
    logic signed [CW-1:0] c_q   [3];
    logic signed [RW-1:0] area_q;
    logic                 overflow_q;
    logic        [15:0]   cull_cnt_q;

    logic signed [DW-1:0] xi, yi, xj, yj;
    logic signed [CW-1:0] prod_ij, prod_ji;
    logic signed [EW-1:0] edge_a, edge_b;
    logic signed [CW-1:0] edge_c;
    logic signed [RW-1:0] area_sum;
    logic                 cull, flip;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign push       = i_dv && (!fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (i_dv && fifo_full && !pop)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pix_q[wr_ptr_q[AW-1:0]] <= i_vertex_pixel;
            mem_z_q[wr_ptr_q[AW-1:0]]   <= i_vertex_z;
            mem_tl_q[wr_ptr_q[AW-1:0]]  <= i_bb_tl;
            mem_br_q[wr_ptr_q[AW-1:0]]  <= i_bb_br;
        end
    end

    // Operand mux feeding the single shared multiplier pair: edge k runs v_k -> v_(k+1 mod 3).
    always_comb begin
        xi = pix_q[2][0];
        yi = pix_q[2][1];
        xj = pix_q[0][0];
        yj = pix_q[0][1];
        case (k_q)
            2'd0: begin
                xi = pix_q[0][0]; yi = pix_q[0][1];
                xj = pix_q[1][0]; yj = pix_q[1][1];
            end
            2'd1: begin
                xi = pix_q[1][0]; yi = pix_q[1][1];
                xj = pix_q[2][0]; yj = pix_q[2][1];
            end
            default: ;
        endcase
    end

    assign prod_ij  = CW'(xi) * CW'(yj);
    assign prod_ji  = CW'(xj) * CW'(yi);
    assign edge_a   = EW'(yi) - EW'(yj);
    assign edge_b   = EW'(xj) - EW'(xi);
    assign edge_c   = prod_ij - prod_ji;
    assign area_sum = RW'(c_q[0]) + RW'(c_q[1]) + RW'(c_q[2]);

`ifdef BACKFACE_CULL_EN
    assign flip = 1'b0;
    assign cull = (state_q == S_AREA) && ((area_sum == '0) || area_sum[RW-1]);
`else
    assign flip = (state_q == S_AREA) && area_sum[RW-1];
    assign cull = (state_q == S_AREA) && (area_sum == '0);
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_EDGE;
                    k_d     = 2'd0;
                end
            end
            S_EDGE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd2)
                    state_d = S_AREA;
            end
            S_AREA:  state_d = cull ? S_IDLE : S_OUT;
            S_OUT:   if (i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // A backward triangle is flipped wholesale so the interior stays on the positive side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                pix_q[i][0] <= '0;
                pix_q[i][1] <= '0;
                z_q[i]      <= '0;
                a_q[i]      <= '0;
                b_q[i]      <= '0;
                c_q[i]      <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                tl_q[i] <= '0;
                br_q[i] <= '0;
            end
            area_q     <= '0;
            cull_cnt_q <= '0;
        end else begin
            if (pop) begin
                pix_q <= mem_pix_q[rd_ptr_q[AW-1:0]];
                z_q   <= mem_z_q[rd_ptr_q[AW-1:0]];
                tl_q  <= mem_tl_q[rd_ptr_q[AW-1:0]];
                br_q  <= mem_br_q[rd_ptr_q[AW-1:0]];
            end
            if (state_q == S_EDGE) begin
                for (int i = 0; i < 3; i++) begin
                    if (k_q == 2'(i)) begin
                        a_q[i] <= edge_a;
                        b_q[i] <= edge_b;
                        c_q[i] <= edge_c;
                    end
                end
            end
            if (state_q == S_AREA) begin
                area_q <= flip ? -area_sum : area_sum;
                if (flip) begin
                    for (int i = 0; i < 3; i++) begin
                        a_q[i] <= -a_q[i];
                        b_q[i] <= -b_q[i];
                        c_q[i] <= -c_q[i];
                    end
                end
            end
            if (cull && (cull_cnt_q != 16'hFFFF))
                cull_cnt_q <= cull_cnt_q + 16'd1;
        end
    end

    assign o_valid      = (state_q == S_OUT);
    assign o_idle       = fifo_empty && (state_q == S_IDLE);
    assign o_overflow   = overflow_q;
    assign o_cull_count = cull_cnt_q;
    assign o_edge_a     = a_q;
    assign o_edge_b     = b_q;
    assign o_edge_c     = c_q;
    assign o_area       = area_q;
    assign o_vertex_z   = z_q;
    assign o_bb_tl      = tl_q;
    assign o_bb_br      = br_q;

endmodule

// File: tb/tb_triangle_setup.sv
// Directed self-checking bench for triangle_setup; expectations are hand-computed.
// Build with BACKFACE_CULL_EN defined to exercise the culling variant.
module tb_triangle_setup;

    localparam int DW = 12;
    localparam int ZW = 12;
    localparam int FD = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_dv = 1'b0;
    logic                 i_ready = 1'b0;
    logic signed [DW-1:0] i_vertex_pixel [3][2];
    logic        [ZW-1:0] i_vertex_z [3];
    logic signed [DW-1:0] i_bb_tl [2];
    logic signed [DW-1:0] i_bb_br [2];
    logic                 o_valid;
    logic signed [DW:0]   o_edge_a [3];
    logic signed [DW:0]   o_edge_b [3];
    logic signed [2*DW:0] o_edge_c [3];
    logic signed [2*DW+1:0] o_area;
    logic        [ZW-1:0] o_vertex_z [3];
    logic signed [DW-1:0] o_bb_tl [2];
    logic signed [DW-1:0] o_bb_br [2];
    logic                 o_idle;
    logic                 o_overflow;
    logic        [15:0]   o_cull_count;

    int checks = 0;
    int errors = 0;

    triangle_setup #(
        .DATAWIDTH(DW),
        .DEPTH_FRACBITS(ZW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_dv(i_dv),
        .i_vertex_pixel(i_vertex_pixel),
        .i_vertex_z(i_vertex_z),
        .i_bb_tl(i_bb_tl),
        .i_bb_br(i_bb_br),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_edge_a(o_edge_a),
        .o_edge_b(o_edge_b),
        .o_edge_c(o_edge_c),
        .o_area(o_area),
        .o_vertex_z(o_vertex_z),
        .o_bb_tl(o_bb_tl),
        .o_bb_br(o_bb_br),
        .o_idle(o_idle),
        .o_overflow(o_overflow),
        .o_cull_count(o_cull_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
        i_vertex_pixel[0][0] = DW'(x0);
        i_vertex_pixel[0][1] = DW'(y0);
        i_vertex_pixel[1][0] = DW'(x1);
        i_vertex_pixel[1][1] = DW'(y1);
        i_vertex_pixel[2][0] = DW'(x2);
        i_vertex_pixel[2][1] = DW'(y2);
    endtask

    task automatic set_attr(input int z0, input int z1, input int z2,
                            input int tlx, input int tly, input int brx, input int bry);
        i_vertex_z[0] = ZW'(z0);
        i_vertex_z[1] = ZW'(z1);
        i_vertex_z[2] = ZW'(z2);
        i_bb_tl[0]    = DW'(tlx);
        i_bb_tl[1]    = DW'(tly);
        i_bb_br[0]    = DW'(brx);
        i_bb_br[1]    = DW'(bry);
    endtask

    // One-cycle i_dv pulse; returns just after the sampling edge with i_dv low.
    task automatic push_one();
        i_dv = 1'b1;
        @(posedge clk); #1;
        i_dv = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (!o_valid && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 1", o_idle); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", o_overflow); end
        checks++; if (o_cull_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_cull: got %0d expected 0", o_cull_count); end
        checks++; if (o_area !== '0) begin errors++; $display("[TB] FAIL reset_area: got %0d expected 0", o_area); end
        checks++; if (o_edge_c[1] !== '0 || o_edge_a[0] !== '0) begin errors++; $display("[TB] FAIL reset_coef: got c1=%0d a0=%0d expected 0", o_edge_c[1], o_edge_a[0]); end
        checks++; if (o_vertex_z[2] !== '0 || o_bb_br[0] !== '0) begin errors++; $display("[TB] FAIL reset_pass: got z2=%0d br0=%0d expected 0", o_vertex_z[2], o_bb_br[0]); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_idle !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_idle: got %b expected 1", o_idle); end
    endtask

    task automatic test_basic();
        int lat;
        int expA[3] = '{0, -10, 10};
        int expB[3] = '{10, -10, 0};
        int expC[3] = '{0, 100, 0};
        int expZ[3] = '{100, 200, 300};
        i_ready = 1'b1;
        set_tri(0, 0, 10, 0, 0, 10);
        set_attr(100, 200, 300, -3, -4, 12, 11);
        push_one();
        checks++; if (o_idle !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_push: got %b expected 0", o_idle); end
        wait_valid(20, lat);
        checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL latency: got %0d cycles expected 5", lat); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (int'(o_edge_a[i]) !== expA[i]) begin errors++; $display("[TB] FAIL basic_A%0d: got %0d expected %0d", i, o_edge_a[i], expA[i]); end
            checks++; if (int'(o_edge_b[i]) !== expB[i]) begin errors++; $display("[TB] FAIL basic_B%0d: got %0d expected %0d", i, o_edge_b[i], expB[i]); end
            checks++; if (int'(o_edge_c[i]) !== expC[i]) begin errors++; $display("[TB] FAIL basic_C%0d: got %0d expected %0d", i, o_edge_c[i], expC[i]); end
            checks++; if (int'(o_vertex_z[i]) !== expZ[i]) begin errors++; $display("[TB] FAIL basic_z%0d: got %0d expected %0d", i, o_vertex_z[i], expZ[i]); end
        end
        checks++; if (int'(o_area) !== 100) begin errors++; $display("[TB] FAIL basic_area: got %0d expected 100", o_area); end
        checks++; if (int'(o_bb_tl[0]) !== -3 || int'(o_bb_tl[1]) !== -4 || int'(o_bb_br[0]) !== 12 || int'(o_bb_br[1]) !== 11)
            begin errors++; $display("[TB] FAIL basic_bbox: got tl=(%0d,%0d) br=(%0d,%0d) expected tl=(-3,-4) br=(12,11)", o_bb_tl[0], o_bb_tl[1], o_bb_br[0], o_bb_br[1]); end
        @(posedge clk); #1;
        checks++; if (o_valid !== 1'b0 || o_idle !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept: got valid=%b idle=%b expected valid=0 idle=1", o_valid, o_idle); end
    endtask

    task automatic test_colinear();
        int seen = 0;
        set_tri(0, 0, 5, 5, 10, 10);
        push_one();
        for (int c = 0; c < 10; c++) begin
            if (o_valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL colinear_valid: got %0d valid cycles expected 0", seen); end
        checks++; if (o_cull_count !== 16'd1) begin errors++; $display("[TB] FAIL colinear_count: got %0d expected 1", o_cull_count); end
        checks++; if (o_idle !== 1'b1) begin errors++; $display("[TB] FAIL colinear_idle: got %b expected 1", o_idle); end
    endtask

    task automatic test_backface();
        int lat;
        set_tri(0, 0, 0, 10, 10, 0);
        push_one();
`ifdef BACKFACE_CULL_EN
        wait_valid(10, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL backface_culled: got valid after %0d cycles expected none", lat); end
        checks++; if (o_cull_count !== 16'd2) begin errors++; $display("[TB] FAIL backface_count: got %0d expected 2", o_cull_count); end
`else
        begin
            int expA[3] = '{10, -10, 0};
            int expB[3] = '{0, -10, 10};
            int expC[3] = '{0, 100, 0};
            wait_valid(20, lat);
            checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL backface_latency: got %0d expected 5", lat); end
            checks++; if (int'(o_area) !== 100) begin errors++; $display("[TB] FAIL backface_area: got %0d expected 100", o_area); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (int'(o_edge_a[i]) !== expA[i] || int'(o_edge_b[i]) !== expB[i] || int'(o_edge_c[i]) !== expC[i]) begin
                    errors++;
                    $display("[TB] FAIL backface_edge%0d: got A=%0d B=%0d C=%0d expected A=%0d B=%0d C=%0d",
                             i, o_edge_a[i], o_edge_b[i], o_edge_c[i], expA[i], expB[i], expC[i]);
                end
            end
            @(posedge clk); #1;
            checks++; if (o_cull_count !== 16'd1) begin errors++; $display("[TB] FAIL backface_count: got %0d expected 1", o_cull_count); end
        end
`endif
    endtask

    task automatic test_corner();
        int lat;
        int expA[3] = '{0, -4095, 4095};
        int expB[3] = '{4095, -4095, 0};
        int expC[3] = '{8386560, -4095, 8386560};
        set_tri(-2048, -2048, 2047, -2048, -2048, 2047);
        push_one();
        wait_valid(20, lat);
        checks++; if (int'(o_area) !== 16769025) begin errors++; $display("[TB] FAIL corner_area: got %0d expected 16769025", o_area); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (int'(o_edge_a[i]) !== expA[i] || int'(o_edge_b[i]) !== expB[i] || int'(o_edge_c[i]) !== expC[i]) begin
                errors++;
                $display("[TB] FAIL corner_edge%0d: got A=%0d B=%0d C=%0d expected A=%0d B=%0d C=%0d",
                         i, o_edge_a[i], o_edge_b[i], o_edge_c[i], expA[i], expB[i], expC[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    // Right triangles with leg s have twice-area s*s, which tags each output uniquely.
    task automatic test_back_to_back();
        int lat;
        int n = 0;
        int got[5];
        i_ready = 1'b0;
        set_tri(0, 0, 1, 0, 0, 1);
        push_one();
        wait_valid(20, lat);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_valid: got %b expected 1", o_valid); end
        for (int s = 2; s <= 6; s++) begin
            if (s == 6) begin
                checks++; if (o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_early_overflow: got %b expected 0", o_overflow); end
            end
            set_tri(0, 0, s, 0, 0, s);
            i_dv = 1'b1;
            @(posedge clk); #1;
        end
        i_dv = 1'b0;
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL b2b_overflow: got %b expected 1", o_overflow); end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (o_valid !== 1'b1 || int'(o_area) !== 1 || int'(o_edge_c[1]) !== 1) begin
                errors++;
                $display("[TB] FAIL b2b_hold: got valid=%b area=%0d c1=%0d expected valid=1 area=1 c1=1", o_valid, o_area, o_edge_c[1]);
            end
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (o_valid) begin
                if (n < 5) got[n] = int'(o_area);
                n++;
            end
            @(posedge clk); #1;
        end
        checks++; if (n !== 5) begin errors++; $display("[TB] FAIL b2b_count: got %0d outputs expected 5", n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (n > i && got[i] !== (i + 1) * (i + 1)) begin errors++; $display("[TB] FAIL b2b_order%0d: got area %0d expected %0d", i, got[i], (i + 1) * (i + 1)); end
        end
        checks++; if (o_overflow !== 1'b1 || o_idle !== 1'b1) begin errors++; $display("[TB] FAIL b2b_end: got overflow=%b idle=%b expected 1 1", o_overflow, o_idle); end
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        i_ready = 1'b1;
        for (int s = 3; s <= 5; s++) begin
            set_tri(0, 0, s, 0, 0, s);
            i_dv = 1'b1;
            @(posedge clk); #1;
        end
        i_dv = 1'b0;
        checks++; if (o_idle !== 1'b0) begin errors++; $display("[TB] FAIL midop_busy: got idle=%b expected 0", o_idle); end
        #2 rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0 || o_idle !== 1'b1) begin errors++; $display("[TB] FAIL midop_flush: got valid=%b idle=%b expected 0 1", o_valid, o_idle); end
        checks++; if (o_cull_count !== 16'd0 || o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL midop_counters: got cull=%0d overflow=%b expected 0 0", o_cull_count, o_overflow); end
        #3 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (o_valid || !o_idle) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midop_after: got %0d busy cycles expected 0", seen); end
    endtask

    initial begin
        set_tri(0, 0, 0, 0, 0, 0);
        set_attr(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_colinear();
        test_backface();
        test_corner();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
